// File: rtl/bgpu_regfile_pkg.sv
// Shared types and helpers for the banked warp register file.
// Optional zero register: BGPU_REGFILE_ZERO_REG_EN.
package bgpu_regfile_pkg;

    localparam int unsigned NumWarps        = 8;
    localparam int unsigned WarpWidth       = 8;
    localparam int unsigned RegIdxWidth     = 6;
    localparam int unsigned RegWidth        = 4;
    localparam int unsigned OperandsPerInst = 3;
    localparam int unsigned NumBanks        = 4;

    localparam int unsigned WidWidth     = $clog2(NumWarps);
    localparam int unsigned BankIdxWidth = $clog2(NumBanks);
    localparam int unsigned PortIdxWidth = $clog2(OperandsPerInst);
    localparam int unsigned DataWidth    = RegWidth * WarpWidth;
    localparam int unsigned RowWidth     = WidWidth + RegIdxWidth - BankIdxWidth;
    localparam int unsigned NumRows      = 2 ** RowWidth;

    typedef logic [WidWidth-1:0]     wid_t;
    typedef logic [RegIdxWidth-1:0]  reg_idx_t;
    typedef logic [DataWidth-1:0]    data_t;
    typedef logic [WarpWidth-1:0]    act_mask_t;
    typedef logic [BankIdxWidth-1:0] bank_idx_t;
    typedef logic [PortIdxWidth-1:0] port_idx_t;
    typedef logic [RowWidth-1:0]     row_t;

    // Skewing by warp id spreads the same register of different warps over banks.
    function automatic bank_idx_t bank_of(input wid_t wid, input reg_idx_t reg_idx);
        return bank_idx_t'(reg_idx[BankIdxWidth-1:0] + wid[BankIdxWidth-1:0]);
    endfunction

    function automatic row_t row_of(input wid_t wid, input reg_idx_t reg_idx);
        return {wid, reg_idx[RegIdxWidth-1:BankIdxWidth]};
    endfunction

endpackage

// File: rtl/register_file_banked_bank.sv
// One register bank: storage, round-robin read arbiter, write priority
// and a one-cycle response register.
module regfile_bank
    import bgpu_regfile_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [OperandsPerInst-1:0] req_valid_i,
    input  row_t                       req_row_i [OperandsPerInst],
    input  logic                       wr_valid_i,
    input  row_t                       wr_row_i,
    input  act_mask_t                  wr_mask_i,
    input  data_t                      wr_data_i,
    output logic [OperandsPerInst-1:0] grant_o,
    output logic [OperandsPerInst-1:0] rsp_valid_o,
    output data_t                      rsp_data_o
);

    data_t                      mem_q [NumRows];
    data_t                      wr_word_d;
    port_idx_t                  ptr_q, ptr_d;
    port_idx_t                  win;
    logic                       found;
    logic [OperandsPerInst-1:0] rsp_valid_q, rsp_valid_d;
    data_t                      rsp_data_q, rsp_data_d;

    // Round-robin search starting at the pointer; a write takes the bank.
    always_comb begin
        found   = 1'b0;
        win     = '0;
        grant_o = '0;
        ptr_d   = ptr_q;
        for (int k = 0; k < int'(OperandsPerInst); k++) begin
            port_idx_t cand;
            cand = port_idx_t'((int'(ptr_q) + k) % int'(OperandsPerInst));
            if (!found && req_valid_i[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        if (!rst_i && !wr_valid_i && found) begin
            grant_o[win] = 1'b1;
            ptr_d = (int'(win) == int'(OperandsPerInst) - 1) ? '0 : win + 1'b1;
        end
    end

    // Merge active lanes of the writeback into the stored row.
    always_comb begin
        wr_word_d = mem_q[wr_row_i];
        for (int l = 0; l < int'(WarpWidth); l++) begin
            if (wr_mask_i[l]) begin
                wr_word_d[l*RegWidth +: RegWidth] = wr_data_i[l*RegWidth +: RegWidth];
            end
        end
    end

    // Response of the granted read, presented the following cycle.
    always_comb begin
        rsp_valid_d = grant_o;
        rsp_data_d  = (|grant_o) ? mem_q[req_row_i[win]] : '0;
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (wr_valid_i && !rst_i) begin
            mem_q[wr_row_i] <= wr_word_d;
        end
    end

    // Arbiter pointer and response register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;

endmodule

// File: rtl/register_file_banked.sv
// Banked warp register file: routes reads/writes to banks, demuxes responses.
// Optional zero register: BGPU_REGFILE_ZERO_REG_EN.
module register_file_banked
    import bgpu_regfile_pkg::*;
(
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [OperandsPerInst-1:0]            opc_read_req_valid_i,
    input  logic [OperandsPerInst*WidWidth-1:0]   opc_read_req_wid_i,
    input  logic [OperandsPerInst*RegIdxWidth-1:0] opc_read_req_reg_idx_i,
    output logic [OperandsPerInst-1:0]            opc_read_req_ready_o,
    output logic [OperandsPerInst-1:0]            opc_read_rsp_valid_o,
    output logic [OperandsPerInst*DataWidth-1:0]  opc_read_rsp_data_o,
    input  logic                                  eu_valid_i,
    input  wid_t                                  eu_wid_i,
    input  reg_idx_t                              eu_dst_i,
    input  act_mask_t                             eu_act_mask_i,
    input  data_t                                 eu_data_i,
    output logic                                  eu_ready_o
);

    wid_t                       req_wid  [OperandsPerInst];
    reg_idx_t                   req_idx  [OperandsPerInst];
    row_t                       req_row  [OperandsPerInst];
    bank_idx_t                  req_bank [OperandsPerInst];
    logic [OperandsPerInst-1:0] bank_req_valid [NumBanks];
    logic [OperandsPerInst-1:0] bank_grant     [NumBanks];
    logic [OperandsPerInst-1:0] bank_rsp_valid [NumBanks];
    data_t                      bank_rsp_data  [NumBanks];
    logic [NumBanks-1:0]        bank_wr_valid;
    logic                       wr_en;
    bank_idx_t                  wr_bank;

    // Unpack request ports and route each to its bank.
    always_comb begin
        for (int i = 0; i < int'(OperandsPerInst); i++) begin
            req_wid[i]  = opc_read_req_wid_i[i*WidWidth +: WidWidth];
            req_idx[i]  = opc_read_req_reg_idx_i[i*RegIdxWidth +: RegIdxWidth];
            req_row[i]  = row_of(req_wid[i], req_idx[i]);
            req_bank[i] = bank_of(req_wid[i], req_idx[i]);
        end
        for (int b = 0; b < int'(NumBanks); b++) begin
            bank_req_valid[b] = '0;
            for (int i = 0; i < int'(OperandsPerInst); i++) begin
                bank_req_valid[b][i] = opc_read_req_valid_i[i] &&
                                       (req_bank[i] == bank_idx_t'(b));
            end
        end
    end

    // Writeback always wins; a discarded zero-register write still handshakes.
    always_comb begin
`ifdef BGPU_REGFILE_ZERO_REG_EN
        wr_en = eu_valid_i && !rst_i && (eu_dst_i != '0);
`else
        wr_en = eu_valid_i && !rst_i;
`endif
        wr_bank = bank_of(eu_wid_i, eu_dst_i);
        for (int b = 0; b < int'(NumBanks); b++) begin
            bank_wr_valid[b] = wr_en && (wr_bank == bank_idx_t'(b));
        end
    end

    assign eu_ready_o = !rst_i;

    for (genvar b = 0; b < int'(NumBanks); b++) begin : g_bank
        regfile_bank u_bank (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .req_valid_i (bank_req_valid[b]),
            .req_row_i   (req_row),
            .wr_valid_i  (bank_wr_valid[b]),
            .wr_row_i    (row_of(eu_wid_i, eu_dst_i)),
            .wr_mask_i   (eu_act_mask_i),
            .wr_data_i   (eu_data_i),
            .grant_o     (bank_grant[b]),
            .rsp_valid_o (bank_rsp_valid[b]),
            .rsp_data_o  (bank_rsp_data[b])
        );
    end

    // A port is ready when any bank grants it.
    always_comb begin
        opc_read_req_ready_o = '0;
        for (int b = 0; b < int'(NumBanks); b++) begin
            opc_read_req_ready_o = opc_read_req_ready_o | bank_grant[b];
        end
    end

`ifdef BGPU_REGFILE_ZERO_REG_EN
    logic [OperandsPerInst-1:0] zero_q, zero_d;

    // Remember which handshakes targeted register 0.
    always_comb begin
        zero_d = '0;
        for (int i = 0; i < int'(OperandsPerInst); i++) begin
            zero_d[i] = opc_read_req_ready_o[i] && (req_idx[i] == '0);
        end
    end

    // Zero-register flags, one per port.
    always_ff @(posedge clk_i) begin
        if (rst_i) zero_q <= '0;
        else       zero_q <= zero_d;
    end
`endif

    // Demux bank responses back onto the port that issued them.
    always_comb begin
        opc_read_rsp_valid_o = '0;
        opc_read_rsp_data_o  = '0;
        for (int i = 0; i < int'(OperandsPerInst); i++) begin
            for (int b = 0; b < int'(NumBanks); b++) begin
                if (bank_rsp_valid[b][i]) begin
                    opc_read_rsp_valid_o[i] = 1'b1;
                    opc_read_rsp_data_o[i*DataWidth +: DataWidth] = bank_rsp_data[b];
                end
            end
`ifdef BGPU_REGFILE_ZERO_REG_EN
            if (zero_q[i]) begin
                opc_read_rsp_data_o[i*DataWidth +: DataWidth] = '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_register_file_banked.sv
// Directed testbench for register_file_banked.
// Honors BGPU_REGFILE_ZERO_REG_EN for the zero-register expectation.
module tb_register_file_banked;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  rd_valid;
    logic [8:0]  rd_wid;
    logic [17:0] rd_idx;
    logic [2:0]  rd_ready;
    logic [2:0]  rsp_valid;
    logic [95:0] rsp_data;
    logic        eu_valid;
    logic [2:0]  eu_wid;
    logic [5:0]  eu_dst;
    logic [7:0]  eu_mask;
    logic [31:0] eu_data;
    logic        eu_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    register_file_banked dut (
        .clk_i                  (clk),
        .rst_i                  (rst),
        .opc_read_req_valid_i   (rd_valid),
        .opc_read_req_wid_i     (rd_wid),
        .opc_read_req_reg_idx_i (rd_idx),
        .opc_read_req_ready_o   (rd_ready),
        .opc_read_rsp_valid_o   (rsp_valid),
        .opc_read_rsp_data_o    (rsp_data),
        .eu_valid_i             (eu_valid),
        .eu_wid_i               (eu_wid),
        .eu_dst_i               (eu_dst),
        .eu_act_mask_i          (eu_mask),
        .eu_data_i              (eu_data),
        .eu_ready_o             (eu_ready)
    );

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input int p, input logic v, input logic [2:0] w, input logic [5:0] r);
        rd_valid[p]       = v;
        rd_wid[p*3 +: 3]  = w;
        rd_idx[p*6 +: 6]  = r;
    endtask

    task automatic wr(input logic v, input logic [2:0] w, input logic [5:0] d,
                      input logic [7:0] m, input logic [31:0] x);
        eu_valid = v;
        eu_wid   = w;
        eu_dst   = d;
        eu_mask  = m;
        eu_data  = x;
    endtask

    logic [31:0] zero_exp;

    initial begin
        rst = 1'b1;
        rd_valid = '0;
        rd_wid = '0;
        rd_idx = '0;
        wr(1'b0, 3'd0, 6'd0, 8'h00, 32'h0);
`ifdef BGPU_REGFILE_ZERO_REG_EN
        zero_exp = 32'h0000_0000;
`else
        zero_exp = 32'hFFFF_FFFF;
`endif

        // Reset: requests present but nothing accepted.
        @(negedge clk);
        rd(0, 1'b1, 3'd2, 6'd5);
        wr(1'b1, 3'd7, 6'd63, 8'hFF, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("rst_ready", {93'd0, rd_ready}, 96'd0);
        chk("rst_eu_ready", {95'd0, eu_ready}, 96'd0);
        chk("rst_rsp_valid", {93'd0, rsp_valid}, 96'd0);
        chk("rst_rsp_data", rsp_data, 96'd0);
        rd(0, 1'b0, 3'd0, 6'd0);
        wr(1'b0, 3'd0, 6'd0, 8'h00, 32'h0);
        rst = 1'b0;

        // Basic round trip.
        @(negedge clk);
        wr(1'b1, 3'd2, 6'd5, 8'hFF, 32'h89AB_CDEF);
        #1 chk("wr_eu_ready", {95'd0, eu_ready}, 96'd1);
        @(negedge clk);
        wr(1'b0, 3'd0, 6'd0, 8'h00, 32'h0);
        rd(0, 1'b1, 3'd2, 6'd5);
        #1 chk("rt_ready", {93'd0, rd_ready}, 96'd1);
        @(negedge clk);
        chk("rt_rsp_valid", {93'd0, rsp_valid}, 96'd1);
        chk("rt_data", {64'd0, rsp_data[31:0]}, {64'd0, 32'h89AB_CDEF});
        rd(0, 1'b0, 3'd0, 6'd0);
        @(negedge clk);
        chk("rt_rsp_gone", {93'd0, rsp_valid}, 96'd0);

        // Partial mask.
        wr(1'b1, 3'd2, 6'd5, 8'h0F, 32'h1111_1111);
        @(negedge clk);
        wr(1'b0, 3'd0, 6'd0, 8'h00, 32'h0);
        rd(0, 1'b1, 3'd2, 6'd5);
        @(negedge clk);
        rd(0, 1'b0, 3'd0, 6'd0);
        chk("pm_data", {64'd0, rsp_data[31:0]}, {64'd0, 32'h89AB_1111});

        // Bank conflict on bank 1: three ports, round-robin.
        wr(1'b1, 3'd0, 6'd1, 8'hFF, 32'hA1A1_A1A1);
        @(negedge clk);
        wr(1'b1, 3'd0, 6'd5, 8'hFF, 32'hA5A5_A5A5);
        @(negedge clk);
        wr(1'b1, 3'd0, 6'd9, 8'hFF, 32'hA9A9_A9A9);
        @(negedge clk);
        wr(1'b0, 3'd0, 6'd0, 8'h00, 32'h0);
        rd(0, 1'b1, 3'd0, 6'd1);
        rd(1, 1'b1, 3'd0, 6'd5);
        rd(2, 1'b1, 3'd0, 6'd9);
        #1 chk("cf_ready0", {93'd0, rd_ready}, 96'd1);
        @(negedge clk);
        chk("cf_rsp0", {93'd0, rsp_valid}, 96'd1);
        chk("cf_data0", {64'd0, rsp_data[31:0]}, {64'd0, 32'hA1A1_A1A1});
        #1 chk("cf_ready1", {93'd0, rd_ready}, 96'd2);
        @(negedge clk);
        chk("cf_rsp1", {93'd0, rsp_valid}, 96'd2);
        chk("cf_data1", {64'd0, rsp_data[63:32]}, {64'd0, 32'hA5A5_A5A5});
        #1 chk("cf_ready2", {93'd0, rd_ready}, 96'd4);
        @(negedge clk);
        chk("cf_rsp2", {93'd0, rsp_valid}, 96'd4);
        chk("cf_data2", {64'd0, rsp_data[95:64]}, {64'd0, 32'hA9A9_A9A9});
        rd(0, 1'b0, 3'd0, 6'd0);
        rd(1, 1'b0, 3'd0, 6'd0);
        rd(2, 1'b0, 3'd0, 6'd0);

        // Write blocks a read of the same bank.
        @(negedge clk);
        wr(1'b1, 3'd0, 6'd1, 8'hFF, 32'h5555_AAAA);
        rd(0, 1'b1, 3'd0, 6'd1);
        #1 chk("wb_eu_ready", {95'd0, eu_ready}, 96'd1);
        chk("wb_rd_blocked", {93'd0, rd_ready}, 96'd0);
        @(negedge clk);
        wr(1'b0, 3'd0, 6'd0, 8'h00, 32'h0);
        chk("wb_no_rsp", {93'd0, rsp_valid}, 96'd0);
        #1 chk("wb_rd_granted", {93'd0, rd_ready}, 96'd1);
        @(negedge clk);
        rd(0, 1'b0, 3'd0, 6'd0);
        chk("wb_rsp", {93'd0, rsp_valid}, 96'd1);
        chk("wb_data", {64'd0, rsp_data[31:0]}, {64'd0, 32'h5555_AAAA});

        // Parallel banks 0,1,2.
        wr(1'b1, 3'd0, 6'd4, 8'hFF, 32'h4444_4444);
        @(negedge clk);
        wr(1'b1, 3'd0, 6'd2, 8'hFF, 32'h2222_2222);
        @(negedge clk);
        wr(1'b0, 3'd0, 6'd0, 8'h00, 32'h0);
        rd(0, 1'b1, 3'd0, 6'd4);
        rd(1, 1'b1, 3'd0, 6'd1);
        rd(2, 1'b1, 3'd0, 6'd2);
        #1 chk("par_ready", {93'd0, rd_ready}, 96'd7);
        @(negedge clk);
        rd(0, 1'b0, 3'd0, 6'd0);
        rd(1, 1'b0, 3'd0, 6'd0);
        rd(2, 1'b0, 3'd0, 6'd0);
        chk("par_rsp", {93'd0, rsp_valid}, 96'd7);
        chk("par_data", rsp_data, {32'h2222_2222, 32'h5555_AAAA, 32'h4444_4444});

        // Zero register.
        wr(1'b1, 3'd1, 6'd0, 8'hFF, 32'hFFFF_FFFF);
        #1 chk("zr_eu_ready", {95'd0, eu_ready}, 96'd1);
        @(negedge clk);
        wr(1'b0, 3'd0, 6'd0, 8'h00, 32'h0);
        rd(0, 1'b1, 3'd1, 6'd0);
        #1 chk("zr_ready", {93'd0, rd_ready}, 96'd1);
        @(negedge clk);
        rd(0, 1'b0, 3'd0, 6'd0);
        chk("zr_data", {64'd0, rsp_data[31:0]}, {64'd0, zero_exp});

        // Reset mid-operation drops the response and clears pointers.
        rd(0, 1'b1, 3'd0, 6'd1);
        #1 chk("mr_ready", {93'd0, rd_ready}, 96'd1);
        @(negedge clk);
        rd(0, 1'b0, 3'd0, 6'd0);
        chk("mr_rsp_pre", {93'd0, rsp_valid}, 96'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mr_rsp_dropped", {93'd0, rsp_valid}, 96'd0);
        rst = 1'b0;
        rd(0, 1'b1, 3'd0, 6'd1);
        rd(2, 1'b1, 3'd0, 6'd5);
        #1 chk("mr_ptr_zero", {93'd0, rd_ready}, 96'd1);
        @(negedge clk);
        rd(0, 1'b0, 3'd0, 6'd0);
        rd(2, 1'b0, 3'd0, 6'd0);
        chk("mr_data", {64'd0, rsp_data[31:0]}, {64'd0, 32'h5555_AAAA});

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file_banked.md
Name: register_file_banked

Overview:
- Banked warp register file: the stage directly downstream of the operand collector's read-request ports, and the source of its read responses.
- Serves one read-request port per operand with valid/ready handshakes.
- Returns data exactly one cycle after each read handshake.
- Accepts one masked writeback per cycle from the execution units.
- Bank conflicts are resolved by per-bank round-robin arbitration.

Parameters:
- NumWarps, 8, warps per compute unit
- WarpWidth, 8, threads per warp
- RegIdxWidth, 6, register index width (64 registers per warp)
- RegWidth, 4, bits per thread register
- OperandsPerInst, 3, read ports
- NumBanks, 4, register banks (power of two, at least 2)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- opc_read_req_valid_i  in  OperandsPerInst  read request valid, per port
- opc_read_req_wid_i  in  OperandsPerInst*$clog2(NumWarps)  warp id, per port
- opc_read_req_reg_idx_i  in  OperandsPerInst*RegIdxWidth  register index, per port
- opc_read_req_ready_o  out  OperandsPerInst  read request accepted, per port
- opc_read_rsp_valid_o  out  OperandsPerInst  response valid, per port
- opc_read_rsp_data_o  out  OperandsPerInst*RegWidth*WarpWidth  response data, per port
- eu_valid_i  in  1  writeback valid
- eu_wid_i  in  $clog2(NumWarps)  writeback warp
- eu_dst_i  in  RegIdxWidth  writeback register
- eu_act_mask_i  in  WarpWidth  lanes to write
- eu_data_i  in  RegWidth*WarpWidth  writeback data
- eu_ready_o  out  1  writeback accepted

Behaviour:
- Single clock clk_i. Reset rst_i is synchronous and active-high.
- Reset values: all ready outputs, rsp_valid and rsp_data are 0. Arbiter pointers are 0. Register storage is not reset and reads X until written.
- Bank mapping: bank = (reg_idx + wid) mod NumBanks, using the low bits. Row within the bank = {wid, reg_idx[RegIdxWidth-1:log2(NumBanks)]}.
- Each bank does one access per cycle: either one write or one read.
- Write priority: eu_ready_o = 1 whenever not in reset, because the write always wins its bank. A valid write blocks every read to that bank in that cycle.
- Writes take effect at the clock edge of the handshake. Only lanes with act_mask=1 are updated. act_mask=0 completes the handshake and changes nothing.
- Reads: each bank has a round-robin arbiter over the ports targeting it. ready_o[i] = 1 only if port i is granted and its bank has no write that cycle. ready_o is combinational from valid_i; valid_i never depends on ready_o.
- Pointer update: advances to the port after the winner only on a granted handshake. It is unchanged on an idle cycle or when the write blocks the bank.
- Response timing: rsp_valid_o[i] is 1 exactly the cycle after port i's handshake and 0 otherwise. rsp_data_o holds that data for that cycle only. No backpressure on responses.
- Simultaneous write and request to the same register: the read stalls, then reads the new value on its granted cycle. There is no read-during-write hazard.
- Ports in different banks all proceed in parallel, so full throughput is OperandsPerInst reads plus 1 write per cycle.
- Reset mid-operation: pending responses are dropped (rsp_valid = 0 the next cycle) and pointers return to 0.

Optional Feature:
- Macro BGPU_REGFILE_ZERO_REG_EN.
- Defined: register index 0 of every warp reads as all zeros, and writes to index 0 are accepted (eu_ready_o=1) but discarded.
- Not defined: index 0 is an ordinary register.

Decomposition:
- Package bgpu_regfile_pkg holds:
  - typedefs wid_t, reg_idx_t, data_t, act_mask_t, bank_idx_t
  - function bank_of(wid, reg_idx)
- Sub-module regfile_bank: one bank holding its storage, round-robin arbiter, write-priority logic and 1-cycle response register. It is instantiated NumBanks times.
- The top level does request-to-bank routing and response demultiplexing.

Test Plan:
- Basic round trip: write wid=2 dst=5 mask=FF data=0x89ABCDEF, then read port0 wid=2 idx=5 -> ready the same cycle, rsp_valid the next cycle with data 0x89ABCDEF.
- Partial mask: write mask=0x0F data=0x11111111 over 0x89ABCDEF -> read returns 0x89AB1111.
- Bank conflict: ports 0,1,2 all request bank 1 (wid=0 idx=1,5,9) every cycle -> grants 0,1,2 on consecutive cycles, three responses over 3 cycles, no port starved.
- Write blocks read: a write to wid=0 idx=1 and a port0 read of bank 1 in the same cycle -> eu_ready=1, port0 ready=0; the next cycle port0 is granted and reads the newly written value.
- Parallel banks: ports target banks 0,1,2 with no write -> all three ready in one cycle, three responses the next cycle.
- Zero register (with the macro defined): write idx=0 data=0xFFFFFFFF, then read idx=0 -> 0x00000000. Without the macro -> 0xFFFFFFFF.
